// File: rtl/regfile_pkg.sv
// Shared types and constants for the parametrised integer register file.
// Optional feature macro: REGFILE_BYPASS_EN (see regfile_param.sv).
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } scrub_state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 32;
  localparam int ZERO_IDX   = 0;

  localparam int NUM_RPORTS = 3;  // rs1, rs2, debug

endpackage

// File: rtl/regfile_scrub.sv
// Scrub sequencer: walks every entry once after reset or on request,
// emitting a zero-write strobe and the index to clear.
module regfile_scrub
  import regfile_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr_req,
  output logic              o_busy,
  output logic              o_scrub_we,
  output logic [ADDR_W-1:0] o_scrub_idx
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  scrub_state_e      r_state;
  scrub_state_e      w_state_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] w_idx_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= CLEAR;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // A request arriving mid-scrub is ignored; the walk never restarts itself.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      IDLE: begin
        if (i_clr_req) begin
          w_state_nxt = CLEAR;
          w_idx_nxt   = '0;
        end
      end
      CLEAR: begin
        if (r_idx == LAST_IDX) w_state_nxt = IDLE;
        else                   w_idx_nxt   = r_idx + 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_busy      = (r_state == CLEAR) || i_rst;
  assign o_scrub_we  = (r_state == CLEAR) && !i_rst;
  assign o_scrub_idx = r_idx;

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: two read ports plus a debug tap, hardwired-zero
// entry 0 and a scrub engine. Macro REGFILE_BYPASS_EN enables write-to-read bypass.
module regfile_param
  import regfile_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic              RegWEn,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clr_req,
  output logic [DATA_W-1:0] Reg_rs1,
  output logic [DATA_W-1:0] Reg_rs2,
  output logic [DATA_W-1:0] Reg_dbg,
  output logic              busy,
  output logic              wr_drop
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_IDX);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_wr_drop;

  logic              w_busy;
  logic              w_scrub_we;
  logic [ADDR_W-1:0] w_scrub_idx;
  logic              w_wr_en;

  logic [NUM_RPORTS-1:0][ADDR_W-1:0] w_raddr;
  logic [NUM_RPORTS-1:0][DATA_W-1:0] w_rdata;
  logic [NUM_RPORTS-1:0]             w_byp;

  regfile_scrub #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_scrub (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_clr_req   (clr_req),
    .o_busy      (w_busy),
    .o_scrub_we  (w_scrub_we),
    .o_scrub_idx (w_scrub_idx)
  );

  assign w_wr_en = RegWEn && !w_busy && (rd != ZERO_ADDR);

  // Storage has no reset; the scrub walk is what brings it to zero.
  always_ff @(posedge clk) begin
    if (w_scrub_we)   r_mem[w_scrub_idx] <= '0;
    else if (w_wr_en) r_mem[rd]          <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) r_wr_drop <= 1'b0;
    else     r_wr_drop <= RegWEn && w_busy;
  end

  assign w_raddr[0] = rs1;
  assign w_raddr[1] = rs2;
  assign w_raddr[2] = dbg_addr;

  for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_rport
`ifdef REGFILE_BYPASS_EN
    assign w_byp[p] = w_wr_en && (rd == w_raddr[p]);
`else
    assign w_byp[p] = 1'b0;
`endif

    always_comb begin
      w_rdata[p] = '0;
      if (!w_busy && (w_raddr[p] != ZERO_ADDR)) begin
        if (w_byp[p]) w_rdata[p] = wdata;
        else          w_rdata[p] = r_mem[w_raddr[p]];
      end
    end
  end

  assign Reg_rs1 = w_rdata[0];
  assign Reg_rs2 = w_rdata[1];
  assign Reg_dbg = w_rdata[2];
  assign busy    = w_busy;
  assign wr_drop = r_wr_drop;

endmodule

// File: tb/tb_regfile_param.sv
// Directed self-checking bench for regfile_param at default size (32 x 32).
module tb_regfile_param;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] rs1, rs2, dbg_addr, rd;
  logic              RegWEn, clr_req;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] Reg_rs1, Reg_rs2, Reg_dbg;
  logic              busy, wr_drop;

  int n_chk  = 0;
  int n_fail = 0;

  regfile_param #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .dbg_addr(dbg_addr),
    .RegWEn(RegWEn), .rd(rd), .wdata(wdata), .clr_req(clr_req),
    .Reg_rs1(Reg_rs1), .Reg_rs2(Reg_rs2), .Reg_dbg(Reg_dbg),
    .busy(busy), .wr_drop(wr_drop)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    RegWEn = 1'b1; rd = a; wdata = d;
    tick();
    RegWEn = 1'b0;
    #1;
  endtask

  // Number of edges until busy drops, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; RegWEn = 1'b1; rd = 5'd4; wdata = 32'hFFFF_FFFF;
    rs1 = 5'd4; rs2 = 5'd1; dbg_addr = 5'd31; clr_req = 1'b0;
    tick(); tick();
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy got %b want 1", busy); end
    n_chk++; if (wr_drop !== 1'b0) begin n_fail++; $display("FAIL reset_wr_drop got %b want 0", wr_drop); end
    n_chk++; if (Reg_rs1 !== 32'h0) begin n_fail++; $display("FAIL reset_rs1 got %h want 0", Reg_rs1); end
    n_chk++; if (Reg_rs2 !== 32'h0) begin n_fail++; $display("FAIL reset_rs2 got %h want 0", Reg_rs2); end
    n_chk++; if (Reg_dbg !== 32'h0) begin n_fail++; $display("FAIL reset_dbg got %h want 0", Reg_dbg); end
    RegWEn = 1'b0;
    rst = 1'b0;
    begin
      int n;
      wait_idle(n);
      n_chk++; if (n !== 32) begin n_fail++; $display("FAIL reset_scrub_len got %0d want 32", n); end
    end
  endtask

  task automatic test_reset_scrub();
    int n;
    for (int i = 1; i < DEPTH; i++) wr(ADDR_W'(i), 32'h0000_0100 + i);
    rs1 = 5'd10; #1;
    n_chk++; if (Reg_rs1 !== 32'h0000_010A) begin n_fail++; $display("FAIL preload_10 got %h want 0000010a", Reg_rs1); end
    rst = 1'b1; tick(); rst = 1'b0;
    wait_idle(n);
    n_chk++; if (n !== 32) begin n_fail++; $display("FAIL rst_pulse_scrub_len got %0d want 32", n); end
    for (int i = 0; i < DEPTH; i++) begin
      rs1 = ADDR_W'(i); #1;
      n_chk++; if (Reg_rs1 !== 32'h0) begin n_fail++; $display("FAIL scrubbed_%0d got %h want 0", i, Reg_rs1); end
    end
  endtask

  task automatic test_basic_write();
    wr(5'd5, 32'hDEAD_BEEF);
    rs1 = 5'd5; #1;
    n_chk++; if (Reg_rs1 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL basic_rs1 got %h want deadbeef", Reg_rs1); end
    n_chk++; if (wr_drop !== 1'b0) begin n_fail++; $display("FAIL basic_wr_drop got %b want 0", wr_drop); end
    wr(5'd31, 32'h8000_0001);
    rs2 = 5'd31; #1;
    n_chk++; if (Reg_rs2 !== 32'h8000_0001) begin n_fail++; $display("FAIL top_entry got %h want 80000001", Reg_rs2); end
  endtask

  task automatic test_zero_dbg();
    wr(5'd0, 32'h1234_5678);
    rs2 = 5'd0; #1;
    n_chk++; if (Reg_rs2 !== 32'h0) begin n_fail++; $display("FAIL zero_entry got %h want 0", Reg_rs2); end
    n_chk++; if (wr_drop !== 1'b0) begin n_fail++; $display("FAIL zero_wr_drop got %b want 0", wr_drop); end
    wr(5'd7, 32'hA5A5_A5A5);
    rs1 = 5'd7; dbg_addr = 5'd7; #1;
    n_chk++; if (Reg_rs1 !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL x7_rs1 got %h want a5a5a5a5", Reg_rs1); end
    n_chk++; if (Reg_dbg !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL x7_dbg got %h want a5a5a5a5", Reg_dbg); end
  endtask

  task automatic test_dropped_write();
    int n;
    wr(5'd9, 32'h0000_0099);
    clr_req = 1'b1; tick();
    clr_req = 1'b0;
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL clr_busy_rise got %b want 1", busy); end
    RegWEn = 1'b1; rd = 5'd9; wdata = 32'hCAFE_0001;
    tick();
    RegWEn = 1'b0; clr_req = 1'b1;  // second request mid-scrub is ignored
    n_chk++; if (wr_drop !== 1'b1) begin n_fail++; $display("FAIL drop_pulse got %b want 1", wr_drop); end
    tick();
    clr_req = 1'b0;
    n_chk++; if (wr_drop !== 1'b0) begin n_fail++; $display("FAIL drop_pulse_end got %b want 0", wr_drop); end
    wait_idle(n);
    n_chk++; if (n !== 30) begin n_fail++; $display("FAIL clr_remaining got %0d want 30", n); end
    rs1 = 5'd9; #1;
    n_chk++; if (Reg_rs1 !== 32'h0) begin n_fail++; $display("FAIL dropped_entry9 got %h want 0", Reg_rs1); end
  endtask

  task automatic test_reset_mid_scrub();
    int n;
    wr(5'd20, 32'h2020_2020);
    wr(5'd30, 32'h3030_3030);
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    for (int i = 0; i < 17; i++) tick();  // scrub_idx now 17
    rs1 = 5'd20; #1;
    n_chk++; if (Reg_rs1 !== 32'h0) begin n_fail++; $display("FAIL mid_busy_read got %h want 0", Reg_rs1); end
    rst = 1'b1; tick(); rst = 1'b0;
    wait_idle(n);
    n_chk++; if (n !== 32) begin n_fail++; $display("FAIL mid_rst_scrub_len got %0d want 32", n); end
    for (int i = 0; i < DEPTH; i++) begin
      dbg_addr = ADDR_W'(i); #1;
      n_chk++; if (Reg_dbg !== 32'h0) begin n_fail++; $display("FAIL mid_scrubbed_%0d got %h want 0", i, Reg_dbg); end
    end
  endtask

  task automatic test_bypass();
    logic [DATA_W-1:0] exp_same;
    wr(5'd3, 32'h1111_1111);
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'h0BAD_F00D;
`else
    exp_same = 32'h1111_1111;
`endif
    rs1 = 5'd3; rs2 = 5'd3;
    RegWEn = 1'b1; rd = 5'd3; wdata = 32'h0BAD_F00D; #1;
    n_chk++; if (Reg_rs1 !== exp_same) begin n_fail++; $display("FAIL byp_rs1_same got %h want %h", Reg_rs1, exp_same); end
    n_chk++; if (Reg_rs2 !== exp_same) begin n_fail++; $display("FAIL byp_rs2_same got %h want %h", Reg_rs2, exp_same); end
    tick();
    RegWEn = 1'b0; #1;
    n_chk++; if (Reg_rs1 !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL byp_rs1_next got %h want 0badf00d", Reg_rs1); end
    n_chk++; if (Reg_rs2 !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL byp_rs2_next got %h want 0badf00d", Reg_rs2); end
  endtask

  initial begin
    test_reset();
    test_reset_scrub();
    test_basic_write();
    test_zero_dbg();
    test_dropped_write();
    test_reset_mid_scrub();
    test_bypass();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised successor to the core's 32×32 integer register file. It has the following features:
- configurable data width and depth;
- two combinational read ports plus one debug read port;
- a hardwired-zero entry 0;
- a sequential scrub engine that zeroes every entry after reset or on request.

It sits between decode (read addresses) and writeback (write port) of the RV32I datapath.

## Interface
Parameters:
- DATA_W, 32, entry width in bits
- DEPTH, 32, number of entries; power of two, ≥ 2
- ADDR_W, $clog2(DEPTH), address width (derived, not overridden)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- rs1  in  ADDR_W  read port 1 address
- rs2  in  ADDR_W  read port 2 address
- dbg_addr  in  ADDR_W  debug read address (generalises the fixed x4 tap)
- RegWEn  in  1  write enable
- rd  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- clr_req  in  1  request a full scrub (single-cycle pulse or level)
- Reg_rs1  out  DATA_W  read data, port 1
- Reg_rs2  out  DATA_W  read data, port 2
- Reg_dbg  out  DATA_W  debug read data
- busy  out  1  scrub in progress; writes are dropped
- wr_drop  out  1  registered pulse: a write was attempted while busy

## Operation
- **FSM states:** IDLE, CLEAR. Counter scrub_idx is ADDR_W bits.
- **rst high:**
  - state ← CLEAR, scrub_idx ← 0, wr_drop ← 0.
  - Storage is not touched while rst is high.
- **CLEAR:**
  - Each cycle, entry[scrub_idx] ← 0, then scrub_idx increments.
  - When scrub_idx == DEPTH−1, it writes and moves to IDLE. No wrap-around.
- **IDLE + clr_req:** move to CLEAR with scrub_idx ← 0 next edge. clr_req is ignored in CLEAR; no restart.
- **busy** = (state == CLEAR) OR rst.
- **Write:**
  - On a rising edge, when RegWEn && !busy && rd != 0, entry[rd] ← wdata.
  - Writes to rd == 0 are discarded silently. They do not raise wr_drop.
- **wr_drop:** registered; set to (RegWEn && busy && !rst). High for exactly one cycle per dropped write.
- **Reads:**
  - Combinational; address 0 always returns 0.
  - While busy, all three read outputs are forced to 0.
- **Simultaneous scrub and write in the same cycle:** the write is dropped and the scrub proceeds.
- **Reset mid-scrub:** the scrub restarts at index 0.

## Timing
- **Reset values:** busy = 1, Reg_rs1 = Reg_rs2 = Reg_dbg = 0, wr_drop = 0.
- **Scrub duration:** busy falls exactly DEPTH cycles after the first edge with rst low. For the default depth, 32 cycles.
- **clr_req in IDLE:**
  - busy rises at the next edge.
  - busy falls DEPTH cycles after that edge.
- **Write latency:** the write is visible on the read ports after the writing edge. With bypass enabled it is visible in the same cycle (see Configuration).
- **Read latency:** zero cycles (combinational from address).
- **wr_drop:** asserted one cycle after the offending write cycle.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- **Defined:**
  - Each read port returns wdata combinationally when RegWEn && !busy && rd != 0 && rd == its read address. This covers rs1, rs2 and dbg_addr.
  - This gives write-before-read in the same cycle.
- **Undefined:** read ports return the stored value until after the writing edge.
- Both builds must be cycle-identical in every other respect.

## Structure
- **Shared package regfile_pkg:**
  - state enum (IDLE, CLEAR);
  - default DATA_W/DEPTH constants;
  - ZERO_IDX constant (0).
- **Sub-module regfile_scrub:** FSM plus scrub_idx counter.
  - Outputs: busy, scrub_we, scrub_idx.
  - Top level muxes the scrub write over the normal write port.
- Storage array and read muxing stay in the top level.

## Test plan
- **Reset scrub:** preload entries via writes, then pulse rst for 1 cycle → busy = 1 for exactly 32 cycles after rst falls. Afterwards, reading all 32 addresses → every entry reads 0x0000_0000.
- **Basic write/read:** write 0xDEAD_BEEF to entry 5 → next cycle rs1 = 5 gives Reg_rs1 = 0xDEAD_BEEF.
- **Zero entry and debug port:** write 0x1234_5678 to rd = 0 → rs2 = 0 gives 0, with wr_drop = 0. Then rs1 = 7 (written with 0xA5A5_A5A5) and dbg_addr = 7 → both return 0xA5A5_A5A5.
- **Dropped write:** assert clr_req, then one cycle later write 0xCAFE_0001 to rd = 9 → wr_drop = 1 for one cycle. After busy falls, entry 9 reads 0.
- **Reset mid-scrub:** assert rst at scrub_idx = 17 → after rst falls, busy stays high a full 32 further cycles, and all entries read 0.
- **Bypass:** write 0x0BAD_F00D to rd = 3 with rs1 = rs2 = 3 in the same cycle.
  - REGFILE_BYPASS_EN defined → Reg_rs1 = Reg_rs2 = 0x0BAD_F00D that cycle.
  - Undefined → the old value that cycle and 0x0BAD_F00D on the next.
